// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and bound-mode constants for the Gray counter
// family. Functions work on a fixed wide vector; callers cast to their width.
package gray_pkg;

    localparam int MAX_W         = 32;
    localparam int WRAP_MODULO   = 1;
    localparam int WRAP_SATURATE = 0;

    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Prefix XOR from the MSB down; zero-extended inputs decode unchanged.
    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] gray);
        logic [MAX_W-1:0] bin;
        bin[MAX_W-1] = gray[MAX_W-1];
        for (int i = MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary converter, shared by Gray-pointer blocks.
module gray_to_bin
    import gray_pkg::*;
#(
    parameter int DATA_WIDTH = 4
) (
    input  logic [DATA_WIDTH-1:0] gray_i,
    output logic [DATA_WIDTH-1:0] bin_o
);

    assign bin_o = DATA_WIDTH'(gray2bin(MAX_W'(gray_i)));

endmodule

// File: rtl/gray_counter_ud.sv
// Up/down Gray-code counter with clear, Gray-coded load, wrap/saturate bounds
// and a registered terminal-count pulse on every boundary step.
module gray_counter_ud
    import gray_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int WRAP       = WRAP_MODULO
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  en,
    input  logic                  up,
    input  logic                  clr,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_val,
    output logic [DATA_WIDTH-1:0] out,
    output logic [DATA_WIDTH-1:0] bin_out,
    output logic                  tc
);

    localparam logic [DATA_WIDTH-1:0] CNT_MAX  = '1;
    localparam bit                    SATURATE = (WRAP == WRAP_SATURATE);

    logic [DATA_WIDTH-1:0] load_bin;
    logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] gray_q;
    logic                  tc_q, tc_d;
    logic                  at_max, at_min;

    gray_to_bin #(.DATA_WIDTH(DATA_WIDTH)) u_load_conv (
        .gray_i (load_val),
        .bin_o  (load_bin)
    );

    assign at_max = (cnt_q == CNT_MAX);
    assign at_min = (cnt_q == '0);

    // Priority clr > load > en > hold; a boundary step pulses tc even when blocked.
    always_comb begin
        cnt_d = cnt_q;
        tc_d  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_bin;
        end else if (en) begin
            if (up) begin
                if (at_max) begin
                    tc_d = 1'b1;
                    if (!SATURATE) cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + DATA_WIDTH'(1);
                end
            end else begin
                if (at_min) begin
                    tc_d = 1'b1;
                    if (!SATURATE) cnt_d = CNT_MAX;
                end else begin
                    cnt_d = cnt_q - DATA_WIDTH'(1);
                end
            end
        end
    end

    // Gray output is registered from the next binary value, so it never glitches.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q  <= '0;
            gray_q <= '0;
            tc_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            gray_q <= DATA_WIDTH'(bin2gray(MAX_W'(cnt_d)));
            tc_q   <= tc_d;
        end
    end

    assign out     = gray_q;
    assign bin_out = cnt_q;
    assign tc      = tc_q;

endmodule

// File: tb/tb_gray_counter_ud.sv
// Bench for gray_counter_ud: vector table, boundary sequences and a random
// sweep at widths 2 and 8 against an arithmetic reference model.
module tb_gray_counter_ud;

    logic clk;
    logic resetn;

    // dut_a: 4-bit wrap, dut_b: 4-bit saturate, dut_c: 2-bit saturate, dut_d: 8-bit wrap
    logic       en_a, up_a, clr_a, load_a, tc_a;
    logic [3:0] lv_a, out_a, bin_a;
    logic       en_b, up_b, clr_b, load_b, tc_b;
    logic [3:0] lv_b, out_b, bin_b;
    logic       en_c, up_c, clr_c, load_c, tc_c;
    logic [1:0] lv_c, out_c, bin_c;
    logic       en_d, up_d, clr_d, load_d, tc_d;
    logic [7:0] lv_d, out_d, bin_d;

    int checks   = 0;
    int failures = 0;
    logic [8:0] exp_q[$];

    typedef struct {
        logic       en;
        logic       up;
        logic       clr;
        logic       load;
        logic [3:0] lv;
        logic [3:0] e_out;
        logic [3:0] e_bin;
        logic       e_tc;
    } vec_t;

    vec_t vecs[$];
    logic [3:0] up_seq[16] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                               4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
    logic [3:0] dn_seq[9]  = '{4'h4, 4'h5, 4'h7, 4'h6, 4'h2, 4'h3, 4'h1, 4'h0, 4'h8};
    logic [3:0] dn_bin[9]  = '{4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1, 4'h0, 4'hF};

    gray_counter_ud #(.DATA_WIDTH(4), .WRAP(1)) dut_a (
        .clk(clk), .resetn(resetn), .en(en_a), .up(up_a), .clr(clr_a), .load(load_a),
        .load_val(lv_a), .out(out_a), .bin_out(bin_a), .tc(tc_a));
    gray_counter_ud #(.DATA_WIDTH(4), .WRAP(0)) dut_b (
        .clk(clk), .resetn(resetn), .en(en_b), .up(up_b), .clr(clr_b), .load(load_b),
        .load_val(lv_b), .out(out_b), .bin_out(bin_b), .tc(tc_b));
    gray_counter_ud #(.DATA_WIDTH(2), .WRAP(0)) dut_c (
        .clk(clk), .resetn(resetn), .en(en_c), .up(up_c), .clr(clr_c), .load(load_c),
        .load_val(lv_c), .out(out_c), .bin_out(bin_c), .tc(tc_c));
    gray_counter_ud #(.DATA_WIDTH(8), .WRAP(1)) dut_d (
        .clk(clk), .resetn(resetn), .en(en_d), .up(up_d), .clr(clr_d), .load(load_d),
        .load_val(lv_d), .out(out_d), .bin_out(bin_d), .tc(tc_d));

    // ---------------- clock / watchdog ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // ---------------- reference helpers ----------------
    function automatic int g_enc(input int b);
        return b ^ (b >> 1);
    endfunction

    function automatic int g_dec(input int g);
        int b = g;
        for (int s = g >> 1; s != 0; s = s >> 1) b = b ^ s;
        return b;
    endfunction

    function automatic void model_step(input int w, input bit wrap, input bit clr, input bit load,
                                       input bit en, input bit up, input int lv,
                                       inout int m, output bit tc);
        int top = (1 << w) - 1;
        tc = 1'b0;
        if (clr) m = 0;
        else if (load) m = g_dec(lv);
        else if (en) begin
            if (up) begin
                if (m == top) begin
                    tc = 1'b1;
                    if (wrap) m = 0;
                end else m = m + 1;
            end else begin
                if (m == 0) begin
                    tc = 1'b1;
                    if (wrap) m = top;
                end else m = m - 1;
            end
        end
    endfunction

    function automatic vec_t mk(input logic en, input logic up, input logic clr, input logic load,
                                input logic [3:0] lv, input logic [3:0] e_out,
                                input logic [3:0] e_bin, input logic e_tc);
        vec_t v;
        v.en = en; v.up = up; v.clr = clr; v.load = load; v.lv = lv;
        v.e_out = e_out; v.e_bin = e_bin; v.e_tc = e_tc;
        return v;
    endfunction

    // ---------------- driver tasks / scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        en_a = 1'b0; up_a = 1'b0; clr_a = 1'b0; load_a = 1'b0; lv_a = '0;
        en_b = 1'b0; up_b = 1'b0; clr_b = 1'b0; load_b = 1'b0; lv_b = '0;
        en_c = 1'b0; up_c = 1'b0; clr_c = 1'b0; load_c = 1'b0; lv_c = '0;
        en_d = 1'b0; up_d = 1'b0; clr_d = 1'b0; load_d = 1'b0; lv_d = '0;
    endtask

    task automatic do_reset();
        idle_all();
        resetn = 1'b0;
        #1;
        chk("reset out_a", 32'(out_a), 32'h0);
        chk("reset bin_a", 32'(bin_a), 32'h0);
        chk("reset tc_a", 32'(tc_a), 32'h0);
        chk("reset out_b", 32'(out_b), 32'h0);
        chk("reset out_c", 32'(out_c), 32'h0);
        chk("reset out_d", 32'(out_d), 32'h0);
        tick();
        chk("reset held out_a", 32'(out_a), 32'h0);
        #1 resetn = 1'b1;
    endtask

    logic [3:0] prev_a;
    logic [1:0] prev_c;
    logic [7:0] prev_d;
    logic [8:0] e;
    int  m_c, m_d, old;
    bit  tcx, step_c, step_d;

    initial begin
        // ---------------- vector table for dut_a ----------------
        for (int i = 0; i < 16; i++)
            vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, up_seq[i], 4'(i + 1), i == 15));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 4'hC, 4'hC, 4'h8, 1'b0));
        for (int i = 0; i < 9; i++)
            vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, dn_seq[i], dn_bin[i], i == 8));
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 4'h0, 4'h0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 4'hF, 4'hA, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'hF, 4'hA, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'hE, 4'hB, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'hF, 4'hA, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 4'h8, 4'h8, 4'hF, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h8, 4'hF, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h8, 4'hF, 1'b0));

        do_reset();

        for (int i = 0; i < vecs.size(); i++) begin
            en_a = vecs[i].en; up_a = vecs[i].up; clr_a = vecs[i].clr;
            load_a = vecs[i].load; lv_a = vecs[i].lv;
            prev_a = out_a;
            tick();
            chk($sformatf("vec%0d out", i), 32'(out_a), 32'(vecs[i].e_out));
            chk($sformatf("vec%0d bin", i), 32'(bin_a), 32'(vecs[i].e_bin));
            chk($sformatf("vec%0d tc", i), 32'(tc_a), 32'(vecs[i].e_tc));
            chk($sformatf("vec%0d gray_rel", i), 32'(out_a), 32'(g_enc(int'(bin_a))));
            if (vecs[i].en && !vecs[i].clr && !vecs[i].load)
                chk($sformatf("vec%0d one_bit", i), 32'($countones(prev_a ^ out_a)), 32'd1);
        end
        idle_all();

        // ---------------- saturation on dut_b ----------------
        en_b = 1'b1; up_b = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            chk($sformatf("sat up%0d bin", i), 32'(bin_b), 32'(i));
            chk($sformatf("sat up%0d tc", i), 32'(tc_b), 32'h0);
        end
        chk("sat top out", 32'(out_b), 32'h8);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("sat hold%0d out", i), 32'(out_b), 32'h8);
            chk($sformatf("sat hold%0d tc", i), 32'(tc_b), 32'h1);
        end
        up_b = 1'b0;
        tick();
        chk("sat back out", 32'(out_b), 32'h9);
        chk("sat back bin", 32'(bin_b), 32'hE);
        chk("sat back tc", 32'(tc_b), 32'h0);
        en_b = 1'b0; load_b = 1'b1; lv_b = 4'h0;
        tick();
        chk("sat load0 out", 32'(out_b), 32'h0);
        load_b = 1'b0; en_b = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("sat low%0d out", i), 32'(out_b), 32'h0);
            chk($sformatf("sat low%0d tc", i), 32'(tc_b), 32'h1);
        end
        en_b = 1'b0;
        tick();
        chk("sat idle tc", 32'(tc_b), 32'h0);

        // ---------------- asynchronous reset mid-count on dut_a ----------------
        do_reset();
        en_a = 1'b1; up_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("pre_rst%0d out", i), 32'(out_a), 32'(up_seq[i]));
        end
        #2 resetn = 1'b0;
        #1;
        chk("async rst out", 32'(out_a), 32'h0);
        chk("async rst bin", 32'(bin_a), 32'h0);
        chk("async rst tc", 32'(tc_a), 32'h0);
        tick();
        chk("rst held out", 32'(out_a), 32'h0);
        #1 resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("post_rst%0d out", i), 32'(out_a), 32'(up_seq[i]));
        end

        // ---------------- random sweep: widths 2 and 8 ----------------
        do_reset();
        m_c = 0; m_d = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            clr_c  = ($urandom_range(0, 15) == 0);
            load_c = ($urandom_range(0, 7) == 0);
            en_c   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) up_c = ~up_c;
            lv_c   = 2'($urandom_range(0, 3));
            old = m_c;
            model_step(2, 1'b0, clr_c, load_c, en_c, up_c, int'(lv_c), m_c, tcx);
            exp_q.push_back({tcx, 8'(m_c)});
            step_c = en_c && !clr_c && !load_c && (old != m_c);

            clr_d  = ($urandom_range(0, 15) == 0);
            load_d = ($urandom_range(0, 7) == 0);
            en_d   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) up_d = ~up_d;
            if ($urandom_range(0, 1) == 1) lv_d = ($urandom_range(0, 1) == 1) ? 8'h80 : 8'h00;
            else lv_d = 8'($urandom_range(0, 255));
            old = m_d;
            model_step(8, 1'b1, clr_d, load_d, en_d, up_d, int'(lv_d), m_d, tcx);
            exp_q.push_back({tcx, 8'(m_d)});
            step_d = en_d && !clr_d && !load_d && (old != m_d);

            prev_c = out_c;
            prev_d = out_d;
            tick();

            e = exp_q.pop_front();
            chk($sformatf("rnd2 c%0d bin", cyc), 32'(bin_c), 32'(e[7:0]));
            chk($sformatf("rnd2 c%0d out", cyc), 32'(out_c), 32'(g_enc(int'(e[7:0]))));
            chk($sformatf("rnd2 c%0d tc", cyc), 32'(tc_c), 32'(e[8]));
            chk($sformatf("rnd2 c%0d gray_rel", cyc), 32'(out_c), 32'(g_enc(int'(bin_c))));
            if (step_c)
                chk($sformatf("rnd2 c%0d one_bit", cyc), 32'($countones(prev_c ^ out_c)), 32'd1);

            e = exp_q.pop_front();
            chk($sformatf("rnd8 c%0d bin", cyc), 32'(bin_d), 32'(e[7:0]));
            chk($sformatf("rnd8 c%0d out", cyc), 32'(out_d), 32'(g_enc(int'(e[7:0]))));
            chk($sformatf("rnd8 c%0d tc", cyc), 32'(tc_d), 32'(e[8]));
            chk($sformatf("rnd8 c%0d gray_rel", cyc), 32'(out_d), 32'(g_enc(int'(bin_d))));
            if (step_d)
                chk($sformatf("rnd8 c%0d one_bit", cyc), 32'($countones(prev_d ^ out_d)), 32'd1);
        end

        // ---------------- final report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
